// File: rtl/game_tick_scheduler_if.sv
// Control/step bundle between the game controller and the timing scheduler.
interface game_tick_scheduler_if;
  logic       start;
  logic       pause;
  logic       collide;
  logic       grav_step;
  logic       pipe_step;
  logic       spawn_step;
  logic [1:0] state;
  logic [2:0] level;

  // Controller side: issues game events, consumes step enables
  modport master (
    output start, pause, collide,
    input  grav_step, pipe_step, spawn_step, state, level
  );

  // Scheduler side: receives game events, produces step enables
  modport slave (
    input  start, pause, collide,
    output grav_step, pipe_step, spawn_step, state, level
  );
endinterface

// File: rtl/game_tick_scheduler.sv
// Game timing controller: divides Clock into a base tick, derives staggered
// gravity/pipe/spawn step enables, runs the game FSM and the speed level.
module game_tick_scheduler #(
  parameter int PRESCALE    = 256,
  parameter int GRAV_DIV    = 2,
  parameter int PIPE_DIV    = 4,
  parameter int SPAWN_DIV   = 32,
  parameter int LEVEL_EVERY = 8
) (
  input logic                  Clock,
  input logic                  RST,
  game_tick_scheduler_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  localparam int BASE_W  = $clog2(PRESCALE);
  localparam int GRAV_W  = $clog2(GRAV_DIV + 1);
  localparam int PIPE_W  = $clog2(PIPE_DIV + 1);
  localparam int SPAWN_W = $clog2(SPAWN_DIV + 1);
  localparam int TALLY_W = $clog2(LEVEL_EVERY + 1);

  localparam logic [BASE_W-1:0]  BASE_LAST  = BASE_W'(PRESCALE - 1);
  localparam logic [GRAV_W-1:0]  GRAV_LAST  = GRAV_W'(GRAV_DIV - 1);
  localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(SPAWN_DIV - 1);
  localparam logic [TALLY_W-1:0] TALLY_LAST = TALLY_W'(LEVEL_EVERY - 1);
  localparam logic [2:0]         LEVEL_MAX  = 3'(PIPE_DIV - 1);

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [BASE_W-1:0]  base_cnt;
  logic [GRAV_W-1:0]  grav_cnt;
  logic [PIPE_W-1:0]  pipe_cnt;
  logic [SPAWN_W-1:0] spawn_cnt;
  logic [TALLY_W-1:0] tally;
  logic [2:0]         level;
  logic [PIPE_W-1:0]  pipe_last;

  logic tick;
  logic restart;
  logic run_next;
  logic grav_fire;
  logic pipe_fire;
  logic spawn_fire;
  logic pipe_pend;
  logic spawn_pend1;
  logic spawn_pend2;
  logic grav_step;
  logic pipe_step;
  logic spawn_step;

  // Next game state; collide has priority over pause while running
  always_comb begin
    // NOTE: default assignment first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE:  if (bus.start) state_next = ST_RUN;
      ST_RUN: begin
        if (bus.collide)    state_next = ST_OVER;
        else if (bus.pause) state_next = ST_PAUSE;
      end
      ST_PAUSE: if (bus.pause) state_next = ST_RUN;
      ST_OVER:  if (bus.start) state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
  end

  // A fresh game starts whenever RUN is entered from IDLE or OVER
  assign restart  = (state == ST_IDLE || state == ST_OVER) && (state_next == ST_RUN);
  assign run_next = (state_next == ST_RUN);
  assign tick     = (state == ST_RUN) && (base_cnt == BASE_LAST);

  // Pipe divisor shrinks with level; >= in the compare absorbs a mid-count shrink
  assign pipe_last  = PIPE_W'(PIPE_DIV - 1) - PIPE_W'(level);
  assign grav_fire  = tick && (grav_cnt >= GRAV_LAST);
  assign pipe_fire  = tick && (pipe_cnt >= pipe_last);
  assign spawn_fire = tick && (spawn_cnt >= SPAWN_LAST);

  // Game state register
  always_ff @(posedge Clock or posedge RST) begin
    // NOTE: non-blocking assignments in clocked blocks so all registers sample pre-edge values.
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Base prescaler: counts RUN cycles, holds in PAUSE, parked at zero otherwise
  always_ff @(posedge Clock or posedge RST) begin
    if (RST)                                     base_cnt <= '0;
    else if (state == ST_RUN)                    base_cnt <= (base_cnt == BASE_LAST) ? '0 : base_cnt + BASE_W'(1);
    else if (state == ST_IDLE || state == ST_OVER) base_cnt <= '0;
  end

  // Step sub-counters advance once per base tick, cleared on a new game
  always_ff @(posedge Clock or posedge RST) begin
    if (RST || restart) begin
      grav_cnt  <= '0;
      pipe_cnt  <= '0;
      spawn_cnt <= '0;
    end else if (tick) begin
      grav_cnt  <= grav_fire  ? '0 : grav_cnt  + GRAV_W'(1);
      pipe_cnt  <= pipe_fire  ? '0 : pipe_cnt  + PIPE_W'(1);
      spawn_cnt <= spawn_fire ? '0 : spawn_cnt + SPAWN_W'(1);
    end
  end

  // Stagger pipeline: grav at T+1, pipe at T+2, spawn at T+3; flushed when not running
  always_ff @(posedge Clock or posedge RST) begin
    if (RST) begin
      grav_step   <= 1'b0;
      pipe_pend   <= 1'b0;
      pipe_step   <= 1'b0;
      spawn_pend1 <= 1'b0;
      spawn_pend2 <= 1'b0;
      spawn_step  <= 1'b0;
    end else if (!run_next || restart) begin
      grav_step   <= 1'b0;
      pipe_pend   <= 1'b0;
      pipe_step   <= 1'b0;
      spawn_pend1 <= 1'b0;
      spawn_pend2 <= 1'b0;
      spawn_step  <= 1'b0;
    end else begin
      grav_step   <= grav_fire;
      pipe_pend   <= pipe_fire;
      pipe_step   <= pipe_pend;
      spawn_pend1 <= spawn_fire;
      spawn_pend2 <= spawn_pend1;
      spawn_step  <= spawn_pend2;
    end
  end

  // Speed level: every LEVEL_EVERY spawns bump the level, saturating at PIPE_DIV-1
  always_ff @(posedge Clock or posedge RST) begin
    if (RST || restart) begin
      tally <= '0;
      level <= '0;
    end else if (spawn_step) begin
      if (tally == TALLY_LAST) begin
        tally <= '0;
        if (level != LEVEL_MAX) level <= level + 3'd1;
      end else begin
        tally <= tally + TALLY_W'(1);
      end
    end
  end

  assign bus.grav_step  = grav_step;
  assign bus.pipe_step  = pipe_step;
  assign bus.spawn_step = spawn_step;
  assign bus.state      = state;
  assign bus.level      = level;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Self-checking bench for game_tick_scheduler: directed scenarios plus a
// randomized phase, all compared against an event-queue reference model.
module tb_game_tick_scheduler;

  localparam int PRESCALE    = 4;
  localparam int GRAV_DIV    = 2;
  localparam int PIPE_DIV    = 3;
  localparam int SPAWN_DIV   = 4;
  localparam int LEVEL_EVERY = 2;

  logic Clock = 1'b0;
  logic RST;

  game_tick_scheduler_if bus ();

  game_tick_scheduler #(
    .PRESCALE   (PRESCALE),
    .GRAV_DIV   (GRAV_DIV),
    .PIPE_DIV   (PIPE_DIV),
    .SPAWN_DIV  (SPAWN_DIV),
    .LEVEL_EVERY(LEVEL_EVERY)
  ) dut (
    .Clock(Clock),
    .RST  (RST),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // Reference model: game state, RUN-cycle phase, ticks since each step last
  // fired, spawns issued this game, and a queue of scheduled step events.
  typedef struct {
    int due;
    int kind;  // 0 grav, 1 pipe, 2 spawn
  } ev_t;

  ev_t evq[$];
  int  m_state, m_phase, m_grav, m_pipe, m_spawn, m_spawns, m_level;
  int  cyc = 0;
  int  gq[$], pq[$], sq[$];
  int  max_level = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic model_reset();
    evq.delete();
    m_state = 0; m_phase = 0; m_grav = 0; m_pipe = 0; m_spawn = 0;
    m_spawns = 0; m_level = 0;
  endtask

  // Advance the model across one rising edge given this cycle's inputs
  task automatic model_advance(input logic s, input logic p, input logic c, input logic spawn_now);
    int  ns;
    bit  fg, fp, fs;
    ns = m_state;
    case (m_state)
      0: if (s) ns = 1;
      1: if (c) ns = 3; else if (p) ns = 2;
      2: if (p) ns = 1;
      3: if (s) ns = 1;
      default: ns = 0;
    endcase
    fg = 0; fp = 0; fs = 0;
    if (m_state == 1 && m_phase == PRESCALE - 1) begin
      m_grav++;  if (m_grav  >= GRAV_DIV)            begin fg = 1; m_grav  = 0; end
      m_pipe++;  if (m_pipe  >= PIPE_DIV - m_level)  begin fp = 1; m_pipe  = 0; end
      m_spawn++; if (m_spawn >= SPAWN_DIV)           begin fs = 1; m_spawn = 0; end
    end
    if (spawn_now) m_spawns++;
    m_level = (m_spawns / LEVEL_EVERY < PIPE_DIV - 1) ? m_spawns / LEVEL_EVERY : PIPE_DIV - 1;
    if (m_state == 1)                     m_phase = (m_phase + 1) % PRESCALE;
    else if (m_state == 0 || m_state == 3) m_phase = 0;
    for (int i = evq.size() - 1; i >= 0; i--)
      if (evq[i].due <= cyc) evq.delete(i);
    if (ns != 1) begin
      evq.delete();
    end else begin
      if (fg) evq.push_back('{cyc + 1, 0});
      if (fp) evq.push_back('{cyc + 2, 1});
      if (fs) evq.push_back('{cyc + 3, 2});
    end
    if ((m_state == 0 || m_state == 3) && ns == 1) begin
      m_phase = 0; m_grav = 0; m_pipe = 0; m_spawn = 0; m_spawns = 0; m_level = 0;
    end
    m_state = ns;
  endtask

  // Called at a falling edge: compare this cycle, drive inputs, advance one cycle
  task automatic step_cycle(input logic s, input logic p, input logic c);
    logic eg, ep, es;
    eg = 1'b0; ep = 1'b0; es = 1'b0;
    foreach (evq[i]) begin
      if (evq[i].due == cyc) begin
        if (evq[i].kind == 0)      eg = 1'b1;
        else if (evq[i].kind == 1) ep = 1'b1;
        else                       es = 1'b1;
      end
    end
    check("state", 32'(bus.state), m_state);
    check("level", 32'(bus.level), m_level);
    check("steps", 32'({bus.grav_step, bus.pipe_step, bus.spawn_step}), 32'({eg, ep, es}));
    check("one_step_max",
          32'(($countones({bus.grav_step, bus.pipe_step, bus.spawn_step}) <= 1) ? 1 : 0), 1);
    if (bus.grav_step === 1'b1)  gq.push_back(cyc);
    if (bus.pipe_step === 1'b1)  pq.push_back(cyc);
    if (bus.spawn_step === 1'b1) sq.push_back(cyc);
    if (int'(bus.level) > max_level) max_level = int'(bus.level);
    bus.start   = s;
    bus.pause   = p;
    bus.collide = c;
    model_advance(s, p, c, es);
    cyc++;
    @(negedge Clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_cycle(1'b0, 1'b0, 1'b0);
  endtask

  int t0;

  initial begin
    RST = 1'b1;
    bus.start = 1'b0; bus.pause = 1'b0; bus.collide = 1'b0;
    model_reset();
    repeat (2) @(negedge Clock);
    check("rst_state", 32'(bus.state), 0);
    check("rst_level", 32'(bus.level), 0);
    check("rst_steps", 32'({bus.grav_step, bus.pipe_step, bus.spawn_step}), 0);
    RST = 1'b0;

    // Idle after reset: nothing happens without start
    idle(50);

    // Basic cadence, level-up and saturation
    gq.delete(); pq.delete(); sq.delete(); max_level = 0;
    t0 = cyc;
    step_cycle(1'b1, 1'b0, 1'b0);
    idle(35);
    check("level_up_at_36", 32'(bus.level), 1);
    idle(124);
    check("grav_1", q_at(gq, 0) - t0, 9);
    check("grav_2", q_at(gq, 1) - t0, 17);
    check("grav_3", q_at(gq, 2) - t0, 25);
    check("pipe_1", q_at(pq, 0) - t0, 14);
    check("pipe_2", q_at(pq, 1) - t0, 26);
    check("spawn_1", q_at(sq, 0) - t0, 19);
    check("spawn_2", q_at(sq, 1) - t0, 35);
    check("pipe_gap_lvl1", q_at(pq, 3) - q_at(pq, 2), 8);
    check("level_sat", 32'(bus.level), 2);
    check("level_max_seen", max_level, 2);
    step_cycle(1'b0, 1'b0, 1'b1);
    idle(3);

    // Pause while a pipe step is pending, ignored events in PAUSE, resume
    gq.delete(); pq.delete(); sq.delete();
    t0 = cyc;
    step_cycle(1'b1, 1'b0, 1'b0);
    idle(12);
    step_cycle(1'b0, 1'b1, 1'b0);
    check("pause_state", 32'(bus.state), 2);
    check("pause_no_pipe", 32'(bus.pipe_step), 0);
    idle(3);
    step_cycle(1'b1, 1'b0, 1'b1);
    idle(3);
    step_cycle(1'b0, 1'b1, 1'b0);
    check("resume_state", 32'(bus.state), 1);
    idle(78);
    check("grav_after_resume", q_at(gq, 1) - t0, 25);

    // Collide and pause together: collide wins
    step_cycle(1'b0, 1'b1, 1'b1);
    check("collide_wins", 32'(bus.state), 3);
    idle(2);
    step_cycle(1'b0, 1'b1, 1'b1);
    idle(4);
    gq.delete();
    t0 = cyc;
    step_cycle(1'b1, 1'b0, 1'b0);
    check("restart_state", 32'(bus.state), 1);
    check("restart_level", 32'(bus.level), 0);
    idle(39);
    check("restart_grav", q_at(gq, 0) - t0, 9);
    check("level_before_rst", 32'(bus.level), 1);

    // Asynchronous reset between edges
    #2 RST = 1'b1;
    #1;
    check("async_state", 32'(bus.state), 0);
    check("async_level", 32'(bus.level), 0);
    check("async_steps", 32'({bus.grav_step, bus.pipe_step, bus.spawn_step}), 0);
    @(negedge Clock);
    RST = 1'b0;
    model_reset();
    idle(5);

    // Randomized event pulses against the model
    for (int i = 0; i < 1500; i++) begin
      step_cycle(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 89) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
Central game-timing controller for the Flappy Bird datapath. It divides Clock into a base game tick and derives staggered single-cycle step enables: gravity (bird), pipe scroll, and pipe spawn. It also runs the game-state machine that gates those enables, and raises pipe speed as the score progresses. Its enables never overlap in a cycle, so the consumers can share one frame-buffer write port.

Parameters:
PRESCALE, 256, Clock cycles per base tick (must be >= 4)
GRAV_DIV, 2, base ticks per grav_step
PIPE_DIV, 4, base ticks per pipe_step at level 0 (must be >= 2)
SPAWN_DIV, 32, base ticks per spawn_step
LEVEL_EVERY, 8, spawn_steps per level increment

Ports:
Clock  in  1  system clock
RST  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins or restarts a game
pause  in  1  single-cycle pulse; toggles RUN/PAUSE
collide  in  1  single-cycle pulse; bird hit pipe or ground
grav_step  out  1  one-cycle enable, bird gravity update
pipe_step  out  1  one-cycle enable, pipe scroll by one column
spawn_step  out  1  one-cycle enable, spawn new pipe pair
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
level  out  3  current speed level, 0..PIPE_DIV-1 (saturating)

Behaviour:
- Clock is the only clock. RST is asynchronous and active-high. On RST: state=IDLE, level=0, all step outputs 0, all counters and pending flags 0.
- FSM transitions, evaluated on rising Clock edges:
  - IDLE -start-> RUN.
  - RUN -collide-> OVER.
  - RUN -pause-> PAUSE.
  - PAUSE -pause-> RUN.
  - OVER -start-> RUN.
  - start in RUN or PAUSE is ignored. collide outside RUN is ignored.
  - If collide and pause are both high in RUN, collide wins and the next state is OVER.
- Entering RUN from IDLE or OVER clears: base counter, grav/pipe/spawn sub-counters, spawn tally, level, and pending flags.
- Base counter:
  - Increments only in RUN, wrapping at PRESCALE-1.
  - The internal base tick is asserted in the cycle where counter == PRESCALE-1.
  - Holds its value in PAUSE. Is cleared in IDLE and OVER.
- Sub-counters advance only on a base tick. Each one: if cnt >= DIV_eff-1, fire and clear; otherwise increment.
  - Gravity uses DIV_eff = GRAV_DIV.
  - Spawn uses DIV_eff = SPAWN_DIV.
  - Pipe uses DIV_eff = PIPE_DIV - level. The >= compare handles the divisor shrinking mid-count.
- Stagger / arbitration:
  - Firing on base tick T sets pending flags.
  - grav_step is high in cycle T+1, pipe_step in T+2, spawn_step in T+3.
  - At most one step output is high in any cycle. PRESCALE >= 4 guarantees no overlap with the next tick.
  - Outputs are registered.
- Leaving RUN (pause or collide) cancels all pending flags. No step outputs are issued outside RUN.
- Level:
  - Each spawn_step increments the spawn tally.
  - When the tally reaches LEVEL_EVERY, the tally clears and level increments, saturating at PIPE_DIV-1.
  - level updates in the cycle after the spawn_step.
- RST mid-game forces IDLE immediately, with outputs low asynchronously.

Test Plan:
(Parameters: PRESCALE=4, GRAV_DIV=2, PIPE_DIV=3, SPAWN_DIV=4, LEVEL_EVERY=2. Start pulse at cycle 0, RUN from cycle 1, base ticks at cycles 4, 8, 12, ...)
1. Reset and idle: RST pulse, then 50 cycles with no start -> state=00, level=0, all steps 0 throughout.
2. Basic cadence: start at cycle 0 -> grav_step high at cycles 9, 17, 25; pipe_step at 14, 26; spawn_step at 19, 35. Never two steps high in one cycle.
3. Level-up: continue scenario 2 -> level=1 at cycle 36. After that, pipe_step comes every 2 base ticks instead of 3. Level saturates at 2 after 4 spawns and never reaches 3.
4. Pause mid-stagger: pause pulse at cycle 13 (pipe_step pending) -> no pipe_step at 14, state=10, base counter frozen. A second pause resumes RUN, and the next base tick arrives after the remaining count, with no lost counter value.
5. Collide vs pause: collide and pause both high in RUN -> state=11, all steps 0. A later start gives state=01 with level=0 and first grav_step 9 cycles after the start edge.
6. Async reset mid-run: RST asserted between clock edges in RUN at level 1 -> state=00, level=0, outputs 0 before the next edge.
